// File: rtl/rf_writeback_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rf_writeback_ctrl_pkg
// Shared widths and the buffered writeback entry type for the register-file
// writeback controller and its result FIFO.
//   REG_ADDR_W : register address width (32 architectural registers)
//   DATA_W     : register data width
//   NUM_REGS   : number of architectural registers (r0 is hardwired zero)
//   wb_entry   : one pending register-file write {addr, data}
// ----------------------------------------------------------------------------
package rf_writeback_ctrl_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [DATA_W-1:0]     data;
   } wb_entry;

endpackage

// File: rtl/rf_writeback_ctrl_wb_fifo.sv
// ----------------------------------------------------------------------------
// wb_fifo
// Synchronous DEPTH-entry FIFO of wb_entry records that buffers long-latency
// results until the register-file write port is free.
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   push        : write push_entry (ignored when full)
//   push_entry  : entry to enqueue
//   pop         : drop the head entry (ignored when empty)
//   head        : current head entry (valid when !empty)
//   full, empty : occupancy flags, from the registered count
//   count       : current occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module wb_fifo
   import rf_writeback_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  wb_entry                      push_entry,
   input  logic                         pop,
   output wb_entry                      head,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   wb_entry          mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] cnt;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally because DEPTH is a power of two.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CNT_W'(1);
            2'b01:   cnt <= cnt - CNT_W'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // NOTE: the storage array is deliberately not reset; the count and
   // pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   assign head  = mem[rd_ptr];
   assign full  = (cnt == FULL_CNT);
   assign empty = (cnt == '0);
   assign count = cnt;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// ----------------------------------------------------------------------------
// rf_writeback_ctrl
// Drives the register file's single write port from the in-order pipeline
// writeback stage (highest priority) and from buffered long-latency results,
// and keeps a per-register scoreboard of outstanding long-latency targets.
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   pipe_wr/addr/data   : pipeline writeback, always accepted
//   lu_issue/_addr      : long-latency op issued, and its destination
//   lu_issue_ok         : issue permitted (combinational)
//   lu_valid/addr/data  : long-latency result offered
//   lu_ready            : result FIFO not full (combinational)
//   chk_addr1/2         : decode source-register queries
//   chk_busy1/2         : queried register has a pending long-latency write
//   rf_wr/addr/data     : registered register-file write port
//   outstanding         : number of scoreboard bits currently set
// ----------------------------------------------------------------------------
module rf_writeback_ctrl
   import rf_writeback_ctrl_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           pipe_wr,
   input  logic [REG_ADDR_W-1:0]          pipe_addr,
   input  logic [DATA_W-1:0]              pipe_data,
   input  logic                           lu_issue,
   input  logic [REG_ADDR_W-1:0]          lu_issue_addr,
   output logic                           lu_issue_ok,
   input  logic                           lu_valid,
   output logic                           lu_ready,
   input  logic [REG_ADDR_W-1:0]          lu_addr,
   input  logic [DATA_W-1:0]              lu_data,
   input  logic [REG_ADDR_W-1:0]          chk_addr1,
   input  logic [REG_ADDR_W-1:0]          chk_addr2,
   output logic                           chk_busy1,
   output logic                           chk_busy2,
   output logic                           rf_wr,
   output logic [REG_ADDR_W-1:0]          rf_addr,
   output logic [DATA_W-1:0]              rf_data,
   output logic [$clog2(MAX_OUT+1)-1:0]   outstanding
);

   localparam int OUT_W = $clog2(MAX_OUT+1);
   localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUT);

   wb_entry             fifo_head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                fifo_push;
   logic                fifo_pop;
   logic                pipe_take;
   logic                rf_from_fifo;
   logic [NUM_REGS-1:0] sb;
   logic [NUM_REGS-1:0] sb_next;
   logic                sb_set;
   logic                sb_clr;

   // A write to r0 from the pipeline is dropped and frees the port.
   assign pipe_take = pipe_wr && (pipe_addr != '0);
   assign fifo_pop  = !pipe_take && !fifo_empty;
   assign fifo_push = lu_valid && !fifo_full;
   assign lu_ready  = !fifo_full;

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (fifo_push),
      .push_entry ('{addr: lu_addr, data: lu_data}),
      .pop        (fifo_pop),
      .head       (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      ()
   );

   // Write port arbiter. rf_from_fifo remembers the source of the write now
   // on the port so the scoreboard clears only once the data is captured.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_wr        <= 1'b0;
         rf_addr      <= '0;
         rf_data      <= '0;
         rf_from_fifo <= 1'b0;
      end else if (pipe_take) begin
         rf_wr        <= 1'b1;
         rf_addr      <= pipe_addr;
         rf_data      <= pipe_data;
         rf_from_fifo <= 1'b0;
      end else if (!fifo_empty) begin
         rf_wr        <= (fifo_head.addr != '0);
         rf_addr      <= fifo_head.addr;
         rf_data      <= fifo_head.data;
         rf_from_fifo <= (fifo_head.addr != '0);
      end else begin
         rf_wr        <= 1'b0;
         rf_from_fifo <= 1'b0;
      end
   end

   assign lu_issue_ok = (outstanding < MAX_OUT_C) &&
                        ((lu_issue_addr == '0) || !sb[lu_issue_addr]);

   assign sb_set = lu_issue && lu_issue_ok && (lu_issue_addr != '0);
   // Only clear a bit that is actually set so the population never underflows
   // on a result that was never issued.
   assign sb_clr = rf_wr && rf_from_fifo && sb[rf_addr];

   // NOTE: combinational blocks assign a full default first, so no path can
   // leave sb_next unassigned and infer a latch.
   always_comb begin
      sb_next = sb;
      if (sb_set) sb_next[lu_issue_addr] = 1'b1;
      if (sb_clr) sb_next[rf_addr]       = 1'b0;
      sb_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sb          <= '0;
         outstanding <= '0;
      end else begin
         sb <= sb_next;
         case ({sb_set, sb_clr})
            2'b10:   outstanding <= outstanding + OUT_W'(1);
            2'b01:   outstanding <= outstanding - OUT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   assign chk_busy1 = (chk_addr1 != '0) && sb[chk_addr1];
   assign chk_busy2 = (chk_addr2 != '0) && sb[chk_addr2];

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rf_writeback_ctrl
// Directed bench for rf_writeback_ctrl. Expected register-file writes are
// queued when stimulus is driven (separate pipe and long-latency queues) and
// compared by a monitor whenever the DUT writes; directed checks cover the
// scoreboard, FIFO flow control, latencies and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_rf_writeback_ctrl;
   import rf_writeback_ctrl_pkg::*;

   logic        clk;
   logic        reset;
   logic        pipe_wr;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        lu_issue;
   logic [4:0]  lu_issue_addr;
   logic        lu_issue_ok;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic [4:0]  chk_addr1;
   logic [4:0]  chk_addr2;
   logic        chk_busy1;
   logic        chk_busy2;
   logic        rf_wr;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic [2:0]  outstanding;

   int      vectors     = 0;
   int      miscompares = 0;
   wb_entry pipe_q[$];
   wb_entry lu_q[$];
   wb_entry mon_e;
   logic    pipe_exp;

   rf_writeback_ctrl #(.DEPTH(4), .MAX_OUT(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .pipe_wr       (pipe_wr),
      .pipe_addr     (pipe_addr),
      .pipe_data     (pipe_data),
      .lu_issue      (lu_issue),
      .lu_issue_addr (lu_issue_addr),
      .lu_issue_ok   (lu_issue_ok),
      .lu_valid      (lu_valid),
      .lu_ready      (lu_ready),
      .lu_addr       (lu_addr),
      .lu_data       (lu_data),
      .chk_addr1     (chk_addr1),
      .chk_addr2     (chk_addr2),
      .chk_busy1     (chk_busy1),
      .chk_busy2     (chk_busy2),
      .rf_wr         (rf_wr),
      .rf_addr       (rf_addr),
      .rf_data       (rf_data),
      .outstanding   (outstanding)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic wb_entry mk(input logic [4:0] a, input logic [31:0] d);
      wb_entry e;
      e.addr = a;
      e.data = d;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pipe_wr       = 1'b0;
      pipe_addr     = '0;
      pipe_data     = '0;
      lu_issue      = 1'b0;
      lu_issue_addr = '0;
      lu_valid      = 1'b0;
      lu_addr       = '0;
      lu_data       = '0;
      chk_addr1     = '0;
      chk_addr2     = '0;
   endtask

   // A pipe write sampled on an edge must be on the port right after it.
   always @(posedge clk or posedge reset) begin
      if (reset) pipe_exp <= 1'b0;
      else       pipe_exp <= pipe_wr && (pipe_addr != '0);
   end

   // Scoreboard monitor: every write is matched to the oldest expected entry
   // of its source.
   always @(negedge clk) begin
      if (!reset) begin
         if (pipe_exp) begin
            check("mon_pipe_wr", rf_wr, 1);
            if (pipe_q.size() == 0) begin
               vectors++;
               miscompares++;
               $error("FAIL mon_pipe_q: observed=empty expected=entry");
            end else begin
               mon_e = pipe_q.pop_front();
               check("mon_pipe_addr", rf_addr, mon_e.addr);
               check("mon_pipe_data", rf_data, mon_e.data);
            end
         end else if (rf_wr) begin
            if (lu_q.size() == 0) begin
               vectors++;
               miscompares++;
               $error("FAIL mon_unexpected_wr: observed=addr 0x%0h expected=no write", rf_addr);
            end else begin
               mon_e = lu_q.pop_front();
               check("mon_lu_addr", rf_addr, mon_e.addr);
               check("mon_lu_data", rf_data, mon_e.data);
            end
         end
      end
   end

   initial begin
      // ---- reset state ----
      reset = 1'b1;
      idle();
      repeat (2) tick();
      check("rst_rf_wr", rf_wr, 0);
      check("rst_rf_addr", rf_addr, 0);
      check("rst_rf_data", rf_data, 0);
      check("rst_lu_ready", lu_ready, 1);
      check("rst_outstanding", outstanding, 0);
      lu_issue_addr = 5'd3;
      chk_addr1 = 5'd3;
      #1;
      check("rst_issue_ok", lu_issue_ok, 1);
      check("rst_busy1", chk_busy1, 0);
      idle();
      reset = 1'b0;
      tick();

      // ---- pipeline write, then a dropped write to r0 ----
      pipe_wr = 1'b1; pipe_addr = 5'd3; pipe_data = 32'hDEADBEEF;
      pipe_q.push_back(mk(5'd3, 32'hDEADBEEF));
      tick();
      check("pipe_rf_wr", rf_wr, 1);
      check("pipe_rf_addr", rf_addr, 3);
      check("pipe_rf_data", rf_data, 32'hDEADBEEF);
      pipe_addr = 5'd0; pipe_data = 32'h5555_5555;
      tick();
      check("pipe_r0_rf_wr", rf_wr, 0);
      check("pipe_r0_hold_addr", rf_addr, 3);
      check("pipe_r0_hold_data", rf_data, 32'hDEADBEEF);
      pipe_wr = 1'b0;

      // ---- long-latency path ----
      lu_issue = 1'b1; lu_issue_addr = 5'd7; chk_addr1 = 5'd7;
      #1;
      check("ll_issue_ok", lu_issue_ok, 1);
      check("ll_busy_pre", chk_busy1, 0);
      tick();
      lu_issue = 1'b0;
      check("ll_busy_set", chk_busy1, 1);
      check("ll_outstanding_1", outstanding, 1);
      lu_valid = 1'b1; lu_addr = 5'd7; lu_data = 32'h1234;
      #1;
      check("ll_ready", lu_ready, 1);
      lu_q.push_back(mk(5'd7, 32'h1234));
      tick();
      lu_valid = 1'b0;
      check("ll_no_bypass", rf_wr, 0);
      tick();
      check("ll_rf_wr", rf_wr, 1);
      check("ll_rf_addr", rf_addr, 7);
      check("ll_rf_data", rf_data, 32'h1234);
      check("ll_busy_until_capture", chk_busy1, 1);
      tick();
      check("ll_busy_clr", chk_busy1, 0);
      check("ll_outstanding_0", outstanding, 0);
      check("ll_rf_wr_idle", rf_wr, 0);

      // ---- priority / starvation ----
      lu_issue = 1'b1; lu_issue_addr = 5'd8;
      tick();
      lu_issue = 1'b0;
      chk_addr2 = 5'd8;
      for (int i = 0; i < 5; i++) begin
         pipe_wr = 1'b1; pipe_addr = 5'(10 + i); pipe_data = 32'h100 + 32'(i);
         pipe_q.push_back(mk(5'(10 + i), 32'h100 + 32'(i)));
         if (i == 0) begin
            lu_valid = 1'b1; lu_addr = 5'd8; lu_data = 32'h88;
            lu_q.push_back(mk(5'd8, 32'h88));
         end
         tick();
         lu_valid = 1'b0;
         check("prio_pipe_addr", rf_addr, 32'(10 + i));
         check("prio_r8_busy", chk_busy2, 1);
      end
      pipe_wr = 1'b0;
      tick();
      check("prio_r8_wr", rf_wr, 1);
      check("prio_r8_addr", rf_addr, 8);
      check("prio_r8_data", rf_data, 32'h88);
      tick();
      check("prio_r8_busy_clr", chk_busy2, 0);
      check("prio_outstanding_0", outstanding, 0);

      // ---- issue limit ----
      for (int k = 1; k <= 4; k++) begin
         lu_issue = 1'b1; lu_issue_addr = 5'(k);
         #1;
         check("cap_issue_ok", lu_issue_ok, 1);
         tick();
      end
      lu_issue = 1'b0; lu_issue_addr = 5'd9;
      #1;
      check("cap_outstanding_4", outstanding, 4);
      check("cap_issue_blocked", lu_issue_ok, 0);

      // ---- FIFO full under continuous pipe writes ----
      for (int k = 0; k < 4; k++) begin
         pipe_wr = 1'b1; pipe_addr = 5'd20; pipe_data = 32'h2000 + 32'(k);
         pipe_q.push_back(mk(5'd20, 32'h2000 + 32'(k)));
         lu_valid = 1'b1; lu_addr = 5'(k + 1); lu_data = 32'hA0 + 32'(k);
         #1;
         check("full_ready_before", lu_ready, 1);
         lu_q.push_back(mk(5'(k + 1), 32'hA0 + 32'(k)));
         tick();
      end
      check("full_ready_low", lu_ready, 0);
      pipe_data = 32'h2004;
      pipe_q.push_back(mk(5'd20, 32'h2004));
      lu_addr = 5'd9; lu_data = 32'hBAD;
      tick();
      check("full_ready_still_low", lu_ready, 0);
      pipe_wr = 1'b0; lu_valid = 1'b0;
      tick();
      check("drain1_wr", rf_wr, 1);
      check("drain1_addr", rf_addr, 1);
      check("drain1_data", rf_data, 32'hA0);
      check("drain1_ready", lu_ready, 1);
      tick();
      check("drain2_addr", rf_addr, 2);
      check("drain2_outstanding", outstanding, 3);
      lu_issue_addr = 5'd2;
      #1;
      check("pend_issue_blocked", lu_issue_ok, 0);
      lu_issue_addr = 5'd1;
      #1;
      check("cleared_issue_ok", lu_issue_ok, 1);
      tick();
      check("drain3_addr", rf_addr, 3);
      check("drain3_outstanding", outstanding, 2);
      tick();
      check("drain4_addr", rf_addr, 4);
      check("drain4_outstanding", outstanding, 1);
      tick();
      check("drain_no_fifth", rf_wr, 0);
      check("drain_outstanding_0", outstanding, 0);
      check("lu_q_consumed", lu_q.size(), 0);
      check("pipe_q_consumed", pipe_q.size(), 0);

      // ---- issue to r0 ----
      lu_issue = 1'b1; lu_issue_addr = 5'd12;
      tick();
      lu_issue_addr = 5'd0;
      #1;
      check("r0_issue_ok", lu_issue_ok, 1);
      tick();
      lu_issue = 1'b0;
      check("r0_outstanding_unchanged", outstanding, 1);

      // ---- asynchronous reset mid-operation ----
      lu_issue = 1'b1; lu_issue_addr = 5'd5; chk_addr1 = 5'd5;
      tick();
      lu_issue = 1'b0;
      check("mid_busy_r5", chk_busy1, 1);
      check("mid_outstanding_2", outstanding, 2);
      pipe_wr = 1'b1; pipe_addr = 5'd9; pipe_data = 32'h99;
      pipe_q.push_back(mk(5'd9, 32'h99));
      lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'h55;
      lu_q.push_back(mk(5'd5, 32'h55));
      tick();
      pipe_data = 32'h9A;
      pipe_q.push_back(mk(5'd9, 32'h9A));
      lu_addr = 5'd6; lu_data = 32'h66;
      lu_q.push_back(mk(5'd6, 32'h66));
      tick();
      lu_valid = 1'b0;
      check("mid_rf_wr_before_rst", rf_wr, 1);
      #2;
      reset = 1'b1;
      idle();
      chk_addr1 = 5'd5;
      #1;
      check("arst_rf_wr", rf_wr, 0);
      check("arst_rf_addr", rf_addr, 0);
      check("arst_rf_data", rf_data, 0);
      check("arst_lu_ready", lu_ready, 1);
      check("arst_outstanding", outstanding, 0);
      check("arst_busy_r5", chk_busy1, 0);
      pipe_q.delete();
      lu_q.delete();
      tick();
      reset = 1'b0;
      repeat (6) tick();
      check("post_rst_no_write", rf_wr, 0);
      check("post_rst_busy_r5", chk_busy1, 0);
      check("post_rst_outstanding", outstanding, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
